ysyx_220066_id_queue: RTL
=========================

Name: ysyx_220066_id_queue

Overview:
- Parametrised decode front end for the RV64 pipeline, placed between IF and EX.
- Buffers fetched instructions in a DEPTH-entry FIFO and extracts register fields and operand-use flags.
- Holds a per-register pending-write scoreboard that replaces the external rs1_valid/rs2_valid inputs; an instruction issues only when it has no RAW hazard and no scoreboard overflow.

Parameters:
- XLEN, 64, PC width.
- DEPTH, 4, FIFO entries; power of 2, minimum 2.
- SB_W, 2, width of each register's pending-write counter; it saturates at 2^SB_W-1.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- in_valid  in  1  IF offers an instruction
- in_ready  out  1  FIFO can accept
- in_instr  in  32  instruction word
- in_pc  in  XLEN  instruction PC
- in_fetch_err  in  1  fetch access fault
- flush  in  1  redirect (jump/trap); squashes the queue
- out_valid  out  1  head instruction issuable
- out_ready  in  1  EX accepts
- out_instr  out  32  head instruction
- out_pc  out  XLEN  head PC
- out_rd, out_rs1, out_rs2  out  5 each  register fields
- out_regwr  out  1  head writes rd (rd!=0)
- out_err  out  1  fetch error or illegal major opcode
- wb_valid  in  1  writeback retires a register write
- wb_rd  in  5  writeback destination

Behaviour:
- Reset (rst==0 at posedge) clears head, tail, count and all scoreboard counters.
- After reset: in_ready=1, out_valid=0. Payload outputs are don't-care while out_valid=0.
- FIFO:
  - in_ready = (count != DEPTH); it does not depend on out_ready.
  - Enqueue on in_valid && in_ready. The entry becomes visible at the head the next cycle (1-cycle latency).
  - Pointers wrap modulo DEPTH. Simultaneous enqueue and dequeue leaves count unchanged.
- Decode (combinational on the head entry):
  - rs1 is used for opcodes 0000011, 0010011, 0011011, 0100011, 0110011, 0111011, 1100011, 1100111, and for 1110011 with funct3[2]==0 and funct3!=000.
  - rs2 is used for 0100011, 0110011, 0111011, 1100011.
  - regwr = rd!=0 and opcode not in {1100011, 0100011}.
  - err = in_fetch_err, or op[1:0]!=11, or major opcode outside the RV64IM+Zicsr set.
- Hazard:
  - hz = (rs1 used && cnt[rs1]!=0) || (rs2 used && cnt[rs2]!=0) || (regwr && cnt[rd]==max).
  - Register x0 is never pending.
  - An errored head does not check hazards; it issues so that EX can raise the trap.
- Issue:
  - out_valid = count!=0 && !hz && !flush.
  - Dequeue on out_valid && out_ready. If the dequeued instruction has regwr, cnt[rd] is incremented.
- Writeback: wb_valid with wb_rd!=0 decrements cnt[wb_rd]. A decrement at zero is ignored and is a verification assertion failure.
- Issue and writeback to the same rd in the same cycle leave the count unchanged.
- Flush:
  - Next cycle count=0 and head=tail=0.
  - A same-cycle enqueue is dropped and no issue occurs.
  - The scoreboard is not cleared, because issued instructions still write back.
  - Flush while the queue is empty is harmless.
- Backpressure: with out_valid=1 and out_ready=0, all out_* fields are held stable.

Optional Feature:
- Macro: YSYX_220066_ID_WB_FWD_EN.
- Defined: a source whose cnt==1 and matches wb_rd with wb_valid in the same cycle is not a hazard, so the instruction issues in the writeback cycle.
- Undefined: issue waits until the cycle after the counter reaches 0.

Decomposition:
- Shared package ysyx_220066_id_pkg holds:
  - opcode localparams (OP_LOAD, OP_OPIMM, OP_OPIMMW, OP_STORE, OP_OP, OP_OPW, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_SYSTEM);
  - the FIFO entry struct {pc, instr, fetch_err}.
- Sub-module ysyx_220066_id_scoreboard:
  - 32 x SB_W counters with inc/dec ports;
  - pending and saturated query outputs for three read indices.

Test Plan:
- Stream: enqueue addi x1,x0,1 (0x00100093) at PC 0x80000000 with out_ready=1 -> out_valid=1 one cycle later, out_rd=1, out_regwr=1; cnt[1] becomes 1.
- RAW: 0x00100093 then add x2,x1,x1 (0x001081B3 adjusted rd=2) -> second instruction is held with out_valid=0 until wb_valid, wb_rd=1; it issues the next cycle, or the same cycle with YSYX_220066_ID_WB_FWD_EN.
- Full/wrap: out_ready=0, push DEPTH instructions -> in_ready=0 after the 4th. Then out_ready=1 -> PCs drain in order, and the pointers wrap across 2×DEPTH pushes.
- Flush: queue holds 3 entries and flush=1 with in_valid=1 -> next cycle out_valid=0 and count=0; the scoreboard counts from earlier issues are retained.
- Saturation: issue 3 writers to x5 with no writeback (SB_W=2) -> the 4th writer to x5 stalls. One wb_rd=5 releases it.
- Illegal: instr 0x00000000 -> out_err=1, out_valid=1 regardless of hazards. in_fetch_err=1 -> out_err=1.

Source files
------------

// File: rtl/ysyx_220066_id_pkg.sv
// Shared definitions for the ID queue. Holds the RV64 major opcodes, the
// FIFO entry layout and small decode helpers. Both rtl/ysyx_220066_id_queue.sv
// and the testbench import it.
package ysyx_220066_id_pkg;

  // The PC field is stored at full RV64 width. Narrower XLEN builds zero-extend it.
  localparam int MAX_XLEN = 64;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OPIMMW = 7'b0011011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OPW    = 7'b0111011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic [MAX_XLEN-1:0] pc;
    logic [31:0]         instr;
    logic                fetch_err;
  } id_entry_t;

  // CSR register forms (CSRRW/CSRRS/CSRRC) read rs1. The immediate forms
  // and ECALL/EBREAK/xRET do not.
  function automatic logic uses_rs1(input logic [6:0] op, input logic [2:0] funct3);
    case (op)
      OP_LOAD, OP_OPIMM, OP_OPIMMW, OP_STORE,
      OP_OP, OP_OPW, OP_BRANCH, OP_JALR: return 1'b1;
      OP_SYSTEM:                         return !funct3[2] && (funct3 != 3'b000);
      default:                           return 1'b0;
    endcase
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    case (op)
      OP_STORE, OP_OP, OP_OPW, OP_BRANCH: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  // Every legal major opcode ends in 2'b11. Compressed encodings therefore
  // fall out as illegal.
  function automatic logic legal_op(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_OPIMM, OP_OPIMMW, OP_STORE, OP_OP, OP_OPW,
      OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_SYSTEM: return 1'b1;
      default:                                                 return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_220066_id_scoreboard.sv
// Per-register pending-write scoreboard. It holds 32 saturating counters of
// width SB_W. Register x0 never counts.
//   clk, rst       clock and synchronous active-low reset (clears all counters)
//   inc_en/inc_idx an instruction writing inc_idx has issued
//   dec_en/dec_idx a writeback to dec_idx has retired
//   q_idx[2:0]     three query indices (rs1, rs2, rd from the ID queue)
//   pending[k]     q_idx[k] has an outstanding write
//   saturated[k]   q_idx[k] counter is at its maximum
// Optional macro YSYX_220066_ID_WB_FWD_EN: a register whose last outstanding
// write retires this cycle is reported as not pending.
module ysyx_220066_id_scoreboard #(
  parameter int SB_W = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inc_en,
  input  logic [4:0]      inc_idx,
  input  logic            dec_en,
  input  logic [4:0]      dec_idx,
  input  logic [2:0][4:0] q_idx,
  output logic [2:0]      pending,
  output logic [2:0]      saturated
);

  localparam logic [SB_W-1:0] CNT_ONE = SB_W'(1);
  localparam logic [SB_W-1:0] CNT_MAX = '1;

  logic [SB_W-1:0] cnt_q [32];
  logic [SB_W-1:0] cnt_d [32];

  always_comb begin
    // NOTE: default every comb output first so no path leaves it unassigned (no latch).
    cnt_d = cnt_q;
    for (int i = 1; i < 32; i++) begin
      // An increment and a decrement on the same register cancel. A decrement at zero is dropped.
      if (inc_en && inc_idx == 5'(i) &&
          !(dec_en && dec_idx == 5'(i) && cnt_q[i] != '0)) begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end else if (dec_en && dec_idx == 5'(i) && cnt_q[i] != '0 &&
                   !(inc_en && inc_idx == 5'(i))) begin
        cnt_d[i] = cnt_q[i] - CNT_ONE;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) cnt_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    pending   = '0;
    saturated = '0;
    for (int k = 0; k < 3; k++) begin
      pending[k]   = (q_idx[k] != 5'd0) && (cnt_q[q_idx[k]] != '0);
      saturated[k] = (q_idx[k] != 5'd0) && (cnt_q[q_idx[k]] == CNT_MAX);
`ifdef YSYX_220066_ID_WB_FWD_EN
      if (dec_en && dec_idx == q_idx[k] && cnt_q[q_idx[k]] == CNT_ONE) pending[k] = 1'b0;
`endif
    end
  end

  // A writeback to a register with no outstanding write indicates a pipeline bug.
  always_ff @(posedge clk) begin
    if (rst && dec_en && dec_idx != 5'd0) begin
      assert (cnt_q[dec_idx] != '0);
    end
  end

endmodule

// File: rtl/ysyx_220066_id_queue.sv
// Decode front end between IF and EX. It buffers fetched instructions in a
// DEPTH-entry FIFO and decodes the head entry's register fields. The head
// issues only when the pending-write scoreboard shows no RAW hazard and no
// counter overflow.
//   clk, rst                  clock, synchronous active-low reset
//   in_*                      IF side: valid/ready, instr, pc, fetch_err
//   flush                     squash the queue (scoreboard kept)
//   out_*                     EX side: valid/ready, instr, pc, rd/rs1/rs2, regwr, err
//   wb_valid, wb_rd           retiring register write
// Optional macro YSYX_220066_ID_WB_FWD_EN: the head may issue in the same
// cycle as the writeback that clears its last hazard.
module ysyx_220066_id_queue
  import ysyx_220066_id_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int DEPTH = 4,
  parameter int SB_W  = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            in_fetch_err,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic            out_regwr,
  output logic            out_err,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd
);

  localparam int         AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  id_entry_t   fifo_q [DEPTH];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [AW:0]   count_q, count_d;

  logic       enq, deq;
  id_entry_t  head;
  logic [6:0] opcode;
  logic       use_rs1, use_rs2, regwr, err, hz;
  logic [2:0] pending, saturated;

  assign in_ready = (count_q != FULL_CNT);
  assign enq      = in_valid && in_ready && !flush;
  assign deq      = out_valid && out_ready;

  // Head decode
  assign head      = fifo_q[head_q];
  assign opcode    = head.instr[6:0];
  assign out_instr = head.instr;
  assign out_pc    = head.pc[XLEN-1:0];
  assign out_rd    = head.instr[11:7];
  assign out_rs1   = head.instr[19:15];
  assign out_rs2   = head.instr[24:20];
  assign use_rs1   = uses_rs1(opcode, head.instr[14:12]);
  assign use_rs2   = uses_rs2(opcode);
  assign regwr     = (out_rd != 5'd0) && (opcode != OP_BRANCH) && (opcode != OP_STORE);
  assign err       = head.fetch_err || !legal_op(opcode);
  assign out_regwr = regwr;
  assign out_err   = err;

  // An errored head skips the hazard check so that EX can raise the trap.
  assign hz = !err && ((use_rs1 && pending[0]) || (use_rs2 && pending[1]) ||
                       (regwr && saturated[2]));
  assign out_valid = (count_q != '0) && !hz && !flush;

  // A trapping instruction never writes back, so it does not claim the
  // counter. Otherwise an unreleased count would stall every later reader.
  ysyx_220066_id_scoreboard #(.SB_W(SB_W)) u_sb (
    .clk       (clk),
    .rst       (rst),
    .inc_en    (deq && regwr && !err),
    .inc_idx   (out_rd),
    .dec_en    (wb_valid && wb_rd != 5'd0),
    .dec_idx   (wb_rd),
    .q_idx     ({out_rd, out_rs2, out_rs1}),
    .pending   (pending),
    .saturated (saturated)
  );

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq) tail_d = tail_q + AW'(1);
      if (deq) head_d = head_q + AW'(1);
      case ({enq, deq})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // NOTE: payload storage is not reset; count_q alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (enq) fifo_q[tail_q] <= '{pc: MAX_XLEN'(in_pc), instr: in_instr, fetch_err: in_fetch_err};
  end

endmodule
